// File: rtl/cmd_uart_wrapper.sv
// UART endpoint for the remote link: reassembles two-byte commands from RX
// and serializes single-byte responses onto TX.
module cmd_uart_wrapper #(
  parameter int BAUD_DIV = 2604,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        trmt,
  input  logic [7:0]  resp,
  output logic        tx_done
);

  localparam logic [11:0] L_HALF = 12'(HALF_DIV - 1);
  localparam logic [11:0] L_BAUD = 12'(BAUD_DIV - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic       {B_HIGH, B_LOW} byte_st_t;
  typedef enum logic       {T_IDLE, T_SHIFT} tx_st_t;

  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  logic        w_rx_fall;
  rx_st_t      r_rx_st;
  logic [11:0] r_rx_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift;
  logic        r_rx_byte_rdy, r_rx_frm_err;

  byte_st_t    r_byte_st;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy, r_cmd_done;

  tx_st_t      r_tx_st;
  logic [11:0] r_tx_cnt;
  logic [3:0]  r_tx_bits;
  logic [8:0]  r_tx_shift;
  logic        r_tx, r_tx_done;

  assign TX      = r_tx;
  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;
  assign tx_done = r_tx_done;

  // RX is asynchronous: two flops for metastability, a third for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_st       <= R_IDLE;
      r_rx_cnt      <= '0;
      r_bit_cnt     <= '0;
      r_rx_shift    <= '0;
      r_rx_byte_rdy <= 1'b0;
      r_rx_frm_err  <= 1'b0;
    end else begin
      r_rx_byte_rdy <= 1'b0;
      r_rx_frm_err  <= 1'b0;
      case (r_rx_st)
        R_IDLE: if (w_rx_fall) begin
          r_rx_st  <= R_START;
          r_rx_cnt <= '0;
        end
        R_START: if (r_rx_cnt == L_HALF) begin
          r_rx_cnt  <= '0;
          r_bit_cnt <= '0;
          r_rx_st   <= r_rx_sync ? R_IDLE : R_DATA;
        end else r_rx_cnt <= r_rx_cnt + 12'd1;
        R_DATA: if (r_rx_cnt == L_BAUD) begin
          r_rx_cnt   <= '0;
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_rx_st <= R_STOP;
        end else r_rx_cnt <= r_rx_cnt + 12'd1;
        R_STOP: if (r_rx_cnt == L_BAUD) begin
          r_rx_cnt <= '0;
          r_rx_st  <= R_IDLE;
          if (r_rx_sync) r_rx_byte_rdy <= 1'b1;
          else           r_rx_frm_err  <= 1'b1;
        end else r_rx_cnt <= r_rx_cnt + 12'd1;
        default: r_rx_st <= R_IDLE;
      endcase
    end
  end

  // A completed command sets cmd_rdy one cycle after the low byte lands and
  // takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_st  <= B_HIGH;
      r_cmd      <= '0;
      r_cmd_rdy  <= 1'b0;
      r_cmd_done <= 1'b0;
    end else begin
      r_cmd_done <= 1'b0;
      if (r_cmd_done)       r_cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
      case (r_byte_st)
        B_HIGH: if (r_rx_byte_rdy) begin
          r_cmd[15:8] <= r_rx_shift;
          r_cmd_rdy   <= 1'b0;
          r_byte_st   <= B_LOW;
        end
        B_LOW: if (r_rx_byte_rdy) begin
          r_cmd[7:0] <= r_rx_shift;
          r_cmd_done <= 1'b1;
          r_byte_st  <= B_HIGH;
        end else if (r_rx_frm_err) r_byte_st <= B_HIGH;
        default: r_byte_st <= B_HIGH;
      endcase
    end
  end

  // Start bit goes out directly at the trmt edge; the shifter holds the
  // remaining data and stop bits, back-filling with idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_st    <= T_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
      r_tx_shift <= '1;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      case (r_tx_st)
        T_IDLE: if (trmt) begin
          r_tx_shift <= {1'b1, resp};
          r_tx       <= 1'b0;
          r_tx_done  <= 1'b0;
          r_tx_cnt   <= '0;
          r_tx_bits  <= '0;
          r_tx_st    <= T_SHIFT;
        end
        T_SHIFT: if (r_tx_cnt == L_BAUD) begin
          r_tx_cnt <= '0;
          if (r_tx_bits == 4'd9) begin
            r_tx_done <= 1'b1;
            r_tx_st   <= T_IDLE;
          end else begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b1, r_tx_shift[8:1]};
            r_tx_bits  <= r_tx_bits + 4'd1;
          end
        end else r_tx_cnt <= r_tx_cnt + 12'd1;
        default: r_tx_st <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Directed bench for cmd_uart_wrapper: vector tables for RX commands and
// TX frames, plus hand sequences for glitch, framing, duplex and reset cases.
module tb_cmd_uart_wrapper;
  localparam int B = 16;

  logic        clk = 1'b0, rst = 1'b1, RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0, trmt = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, tx_done;
  logic [15:0] cmd;

  int n_pass = 0, n_tot = 0;

  cmd_uart_wrapper #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .trmt(trmt), .resp(resp), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b0; logic [7:0] b1; logic [15:0] exp_cmd; } rxv_t;
  typedef struct { logic [7:0] r; logic [9:0] wave; logic mid; } txv_t;
  rxv_t rxv [4];
  txv_t txv [3];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic rx_send(logic [7:0] b, logic stop);
    @(negedge clk);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = stop;
    repeat (B) @(negedge clk);
    RX = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rdy(string nm);
    int k = 0;
    while (!cmd_rdy && k < 4 * B) begin
      @(negedge clk);
      k++;
    end
    chk(nm, cmd_rdy, 1);
  endtask

  task automatic wait_rdy_clr();
    int k = 0;
    while (!cmd_rdy && k < 14 * B) begin
      @(negedge clk);
      k++;
    end
    clr_cmd_rdy = 1'b0;
    chk("rdy_wins_over_clr", cmd_rdy, 1);
  endtask

  task automatic clr_pulse(string nm);
    @(negedge clk) clr_cmd_rdy = 1'b1;
    @(negedge clk) clr_cmd_rdy = 1'b0;
    chk(nm, cmd_rdy, 0);
  endtask

  // wave[i] is the level expected during bit period i (0 = start, 9 = stop).
  task automatic tx_frame(logic [7:0] r, logic [9:0] wave, logic mid);
    @(negedge clk);
    trmt = 1'b1; resp = r;
    @(negedge clk);
    trmt = 1'b0; resp = 8'h00;
    chk("tx_done_clr", tx_done, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) repeat (B / 2) @(negedge clk);
      else if (mid && i == 4) begin
        trmt = 1'b1; resp = 8'h5A;
        @(negedge clk);
        trmt = 1'b0; resp = 8'h00;
        repeat (B - 1) @(negedge clk);
      end else repeat (B) @(negedge clk);
      chk($sformatf("tx_bit%0d_%0h", i, r), TX, wave[i]);
    end
    repeat (B / 2 - 1) @(negedge clk);
    chk("tx_done_early", tx_done, 0);
    @(negedge clk);
    chk("tx_done_set", tx_done, 1);
    chk("tx_idle_high", TX, 1);
  endtask

  initial begin
    rxv[0] = '{8'h60, 8'h00, 16'h6000};
    rxv[1] = '{8'hA5, 8'h5A, 16'hA55A};
    rxv[2] = '{8'hFF, 8'h01, 16'hFF01};
    rxv[3] = '{8'h00, 8'h80, 16'h0080};
    txv[0] = '{8'hA5, 10'h34A, 1'b1};
    txv[1] = '{8'h00, 10'h200, 1'b0};
    txv[2] = '{8'hFF, 10'h3FE, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_tx", TX, 1);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_rdy", cmd_rdy, 0);
    chk("rst_done", tx_done, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_tx", TX, 1);
    chk("post_rst_rdy", cmd_rdy, 0);

    for (int v = 0; v < 4; v++) begin
      rx_send(rxv[v].b0, 1'b1);
      chk("rdy_after_hi", cmd_rdy, 0);
      rx_send(rxv[v].b1, 1'b1);
      wait_rdy("rx_rdy");
      chk("rx_cmd", cmd, rxv[v].exp_cmd);
      repeat (20) @(negedge clk);
      chk("rdy_held", cmd_rdy, 1);
      chk("cmd_stable", cmd, rxv[v].exp_cmd);
      clr_pulse("rdy_cleared");
    end

    for (int v = 0; v < 3; v++) begin
      tx_frame(txv[v].r, txv[v].wave, txv[v].mid);
      repeat (30) @(negedge clk);
      chk("tx_done_held", tx_done, 1);
    end

    // short low glitch on idle RX must be rejected as a false start
    @(negedge clk) RX = 1'b0;
    repeat (2) @(negedge clk);
    RX = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk("glitch_no_rdy", cmd_rdy, 0);
    rx_send(8'h12, 1'b1);
    rx_send(8'h34, 1'b1);
    wait_rdy("glitch_rdy");
    chk("glitch_cmd", cmd, 16'h1234);
    clr_pulse("glitch_clr");

    // framing error on a low byte drops the partial command
    rx_send(8'h77, 1'b1);
    rx_send(8'h12, 1'b0);
    repeat (2 * B) @(negedge clk);
    chk("frm_no_rdy", cmd_rdy, 0);
    rx_send(8'hAB, 1'b1);
    rx_send(8'hCD, 1'b1);
    wait_rdy("frm_rdy");
    chk("frm_cmd", cmd, 16'hABCD);
    clr_pulse("frm_clr");

    fork
      begin
        rx_send(8'h29, 1'b1);
        rx_send(8'h01, 1'b1);
      end
      tx_frame(8'hA5, 10'h34A, 1'b0);
    join
    wait_rdy("fd_rdy");
    chk("fd_cmd", cmd, 16'h2901);
    rx_send(8'h40, 1'b1);
    chk("hi_clears_rdy", cmd_rdy, 0);
    clr_cmd_rdy = 1'b1;
    fork
      rx_send(8'h00, 1'b1);
      wait_rdy_clr();
    join
    repeat (4) @(negedge clk);
    chk("coll_rdy_kept", cmd_rdy, 1);
    chk("coll_cmd", cmd, 16'h4000);

    // reset in the middle of RX byte 2 and a TX frame
    rx_send(8'h60, 1'b1);
    @(negedge clk);
    trmt = 1'b1; resp = 8'h00;
    @(negedge clk);
    trmt = 1'b0;
    RX = 1'b0;
    repeat (5 * B) @(negedge clk);
    chk("pre_rst_tx_low", TX, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", TX, 1);
    chk("mid_rst_cmd", cmd, 16'h0000);
    chk("mid_rst_rdy", cmd_rdy, 0);
    chk("mid_rst_done", tx_done, 0);
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5 * B) @(negedge clk);
    chk("after_rst_rdy", cmd_rdy, 0);
    rx_send(8'h60, 1'b1);
    rx_send(8'h00, 1'b1);
    wait_rdy("after_rst_rdy2");
    chk("after_rst_cmd", cmd, 16'h6000);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
